// File: rtl/m_axi_rd_arbiter.sv
// Two-master AXI read-address/read-data arbiter onto one memory port, one burst at a time.
// Optional ARB_ROUND_ROBIN_EN: round-robin on simultaneous requests; default build is fixed priority (m1 over m0).
module m_axi_rd_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_araddr,
  input  logic        m0_arvalid,
  input  logic [7:0]  m0_arlen,
  output logic        m0_arready,
  output logic [63:0] m0_rdata,
  output logic [1:0]  m0_rresp,
  output logic        m0_rvalid,
  output logic        m0_rlast,
  input  logic        m0_rready,
  input  logic [31:0] m1_araddr,
  input  logic        m1_arvalid,
  input  logic [7:0]  m1_arlen,
  output logic        m1_arready,
  output logic [63:0] m1_rdata,
  output logic [1:0]  m1_rresp,
  output logic        m1_rvalid,
  output logic        m1_rlast,
  input  logic        m1_rready,
  output logic [31:0] s_araddr,
  output logic        s_arvalid,
  output logic [7:0]  s_arlen,
  output logic [2:0]  s_arsize,
  output logic [1:0]  s_arburst,
  input  logic        s_arready,
  input  logic [63:0] s_rdata,
  input  logic [1:0]  s_rresp,
  input  logic        s_rvalid,
  input  logic        s_rlast,
  output logic        s_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   pick_m1;
  logic   sel_arvalid;
  logic   sel_rready;
`ifdef ARB_ROUND_ROBIN_EN
  logic   last_grant_q, last_grant_d;
`endif

  assign s_arsize  = 3'd3;
  assign s_arburst = 2'b01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
    // On a tie, hand the bus to whichever master did not finish the previous burst.
    pick_m1      = (m0_arvalid && m1_arvalid) ? ~last_grant_q : m1_arvalid;
`else
    pick_m1      = m1_arvalid;
`endif
    sel_arvalid  = grant_q ? m1_arvalid : m0_arvalid;
    sel_rready   = grant_q ? m1_rready  : m0_rready;

    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arlen    = '0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rvalid  = 1'b0;
    m0_rlast   = 1'b0;
    m1_arready = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rvalid  = 1'b0;
    m1_rlast   = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          state_d = ADDR;
          grant_d = pick_m1;
        end
      end
      ADDR: begin
        s_arvalid = sel_arvalid;
        s_araddr  = grant_q ? m1_araddr : m0_araddr;
        s_arlen   = grant_q ? m1_arlen  : m0_arlen;
        if (grant_q) m1_arready = s_arready;
        else         m0_arready = s_arready;
        // A withdrawn request abandons the grant without issuing anything.
        if (!sel_arvalid)   state_d = IDLE;
        else if (s_arready) state_d = DATA;
      end
      DATA: begin
        s_rready = sel_rready;
        if (grant_q) begin
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
          m1_rvalid = s_rvalid;
          m1_rlast  = s_rlast;
        end else begin
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
          m0_rvalid = s_rvalid;
          m0_rlast  = s_rlast;
        end
        if (s_rvalid && sel_rready && s_rlast) begin
          state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = grant_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_m_axi_rd_arbiter.sv
// Self-checking bench for m_axi_rd_arbiter: pending-request model picks each burst's owner, bench acts as memory.
module tb_m_axi_rd_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  arvalid_i;
  logic [31:0] araddr_i [2];
  logic [7:0]  arlen_i [2];
  logic [1:0]  rready_i;
  logic        m0_arready, m0_rvalid, m0_rlast, m1_arready, m1_rvalid, m1_rlast;
  logic [63:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic [31:0] s_araddr;
  logic        s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic [63:0] s_rdata;

  logic [1:0]  arready_o, rvalid_o, rlast_o;
  logic [63:0] rdata_o [2];
  logic [1:0]  rresp_o [2];
  assign arready_o  = {m1_arready, m0_arready};
  assign rvalid_o   = {m1_rvalid, m0_rvalid};
  assign rlast_o    = {m1_rlast, m0_rlast};
  assign rdata_o[0] = m0_rdata;
  assign rdata_o[1] = m1_rdata;
  assign rresp_o[0] = m0_rresp;
  assign rresp_o[1] = m1_rresp;

  always #5 clk = ~clk;

  m_axi_rd_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_araddr(araddr_i[0]), .m0_arvalid(arvalid_i[0]), .m0_arlen(arlen_i[0]), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast), .m0_rready(rready_i[0]),
    .m1_araddr(araddr_i[1]), .m1_arvalid(arvalid_i[1]), .m1_arlen(arlen_i[1]), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast), .m1_rready(rready_i[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
    .s_rready(s_rready)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: outstanding request per master plus who finished the last burst.
  bit          p_valid [2];
  logic [31:0] p_addr [2];
  logic [7:0]  p_len [2];
  bit          last_grant_m;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag, input bit m);
    chk(tag, 128'({arready_o[m], rvalid_o[m], rlast_o[m], rresp_o[m], rdata_o[m]}), '0);
  endtask

  function automatic bit pick();
    if (p_valid[0] && p_valid[1]) return RR ? !last_grant_m : 1'b1;
    return p_valid[1];
  endfunction

  task automatic new_req(input bit m, input logic [31:0] addr, input logic [7:0] len);
    p_valid[m] = 1'b1;
    p_addr[m]  = addr;
    p_len[m]   = len;
  endtask

  task automatic drive_ar();
    for (int m = 0; m < 2; m++) begin
      arvalid_i[m] = p_valid[m];
      araddr_i[m]  = p_addr[m];
      arlen_i[m]   = p_len[m];
    end
  endtask

  // Starts at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
  task automatic run_burst(input int rst_beat, input int stall_at, input int err_beat);
    bit w;
    bit fire;
    bit stall_done;
    int beat, cyc, ar_wait, stall_left;
    w = pick();
    drive_ar();
    #1;
    chk("idle_s_arvalid", 128'(s_arvalid), '0);
    chk("idle_s_rready", 128'(s_rready), '0);
    chk_quiet("idle_m0", 1'b0);
    chk_quiet("idle_m1", 1'b1);
    @(posedge clk); #1;

    ar_wait = int'($urandom_range(0, 3));
    for (int i = 0; i <= ar_wait; i++) begin
      s_arready = (i == ar_wait);
      #1;
      chk("addr_s_arvalid", 128'(s_arvalid), 128'(1'b1));
      chk("addr_s_addr_len", 128'({s_araddr, s_arlen}), 128'({p_addr[w], p_len[w]}));
      chk("addr_arready", 128'(arready_o[w]), 128'(s_arready));
      chk("addr_s_rready", 128'(s_rready), '0);
      chk_quiet("addr_loser", ~w);
      @(posedge clk); #1;
    end
    s_arready  = 1'b0;
    p_valid[w] = 1'b0;
    drive_ar();

    beat = 0; cyc = 0; stall_left = 0; stall_done = 1'b0;
    while (beat <= int'(p_len[w]) && cyc < 300) begin
      if (beat == stall_at && !stall_done) begin
        stall_left = 3;
        stall_done = 1'b1;
      end
      s_rvalid    = (stall_left > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      rready_i[w] = (stall_left > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      rready_i[~w] = 1'($urandom_range(0, 1));
      s_rdata     = {p_addr[w], 32'((beat + 1) * 17)};
      s_rresp     = (beat == err_beat) ? 2'b10 : 2'b00;
      s_rlast     = s_rvalid && (beat == int'(p_len[w]));
      #1;
      if (beat == rst_beat && s_rvalid) begin
        rst_n = 1'b0;
        #1;
        chk("rst_s_side", 128'({s_arvalid, s_rready, s_araddr, s_arlen}), '0);
        chk_quiet("rst_m0", 1'b0);
        chk_quiet("rst_m1", 1'b1);
        s_rvalid = 1'b0; s_rlast = 1'b0; rready_i = '0;
        p_valid[0] = 1'b0; p_valid[1] = 1'b0;
        drive_ar();
        last_grant_m = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      chk("data_fwd", 128'({rvalid_o[w], rlast_o[w], rresp_o[w], rdata_o[w]}),
          128'({s_rvalid, s_rlast, s_rresp, s_rdata}));
      chk("data_s_rready", 128'(s_rready), 128'(rready_i[w]));
      chk("data_no_addr", 128'({s_arvalid, arready_o}), '0);
      chk_quiet("data_loser", ~w);
      fire = s_rvalid && rready_i[w];
      @(posedge clk); #1;
      if (stall_left > 0) stall_left--;
      if (fire) beat++;
      cyc++;
    end
    s_rvalid = 1'b0; s_rlast = 1'b0; rready_i = '0;
    last_grant_m = w;
  endtask

  initial begin
    rst_n = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; s_rresp = '0;
    rready_i = '0;
    p_valid[0] = 1'b0; p_valid[1] = 1'b0;
    p_addr[0] = '0; p_addr[1] = '0; p_len[0] = '0; p_len[1] = '0;
    last_grant_m = 1'b0;
    drive_ar();
    #3;
    chk("reset_s_side", 128'({s_arvalid, s_rready, s_araddr, s_arlen}), '0);
    chk("reset_consts", 128'({s_arsize, s_arburst}), 128'({3'd3, 2'b01}));
    chk_quiet("reset_m0", 1'b0);
    chk_quiet("reset_m1", 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single m0 burst, 8 beats.
    new_req(1'b0, 32'h8000_0040, 8'd7);
    run_burst(-1, -1, -1);

    // Simultaneous requests, then m1 asks again while m0 is still waiting.
    new_req(1'b0, 32'h0000_0100, 8'd3);
    new_req(1'b1, 32'h0000_0200, 8'd2);
    run_burst(-1, -1, -1);
    if (!p_valid[1]) new_req(1'b1, 32'h0000_0300, 8'd1);
    run_burst(-1, -1, -1);
    while (p_valid[0] || p_valid[1]) run_burst(-1, -1, -1);

    // m0 stalls rready for three cycles mid-burst.
    new_req(1'b0, 32'h0000_0400, 8'd7);
    run_burst(-1, 4, -1);

    // Error response on one beat of an m1 burst.
    new_req(1'b1, 32'h0000_0500, 8'd7);
    run_burst(-1, -1, 2);

    // m1 withdraws its request in ADDR before the memory accepts it.
    new_req(1'b1, 32'h0000_1000, 8'd3);
    drive_ar();
    #1;
    chk("drop_idle_s_arvalid", 128'(s_arvalid), '0);
    @(posedge clk); #1;
    s_arready = 1'b0;
    #1;
    chk("drop_addr_s_arvalid", 128'(s_arvalid), 128'(1'b1));
    @(posedge clk); #1;
    p_valid[1] = 1'b0;
    drive_ar();
    #1;
    chk("drop_s_arvalid", 128'({s_arvalid, arready_o}), '0);
    @(posedge clk); #1;
    new_req(1'b1, 32'h0000_2000, 8'd1);
    run_burst(-1, -1, -1);

    // Reset during the fourth beat of an m0 burst, then a normal m1 burst.
    new_req(1'b0, 32'h0000_3000, 8'd7);
    run_burst(3, -1, -1);
    new_req(1'b1, 32'h0000_4000, 8'd5);
    run_burst(-1, -1, -1);

    repeat (40) begin
      for (int m = 0; m < 2; m++)
        if (!p_valid[m] && $urandom_range(0, 1) == 1)
          new_req(1'(m), 32'($urandom) & 32'hFFFF_FFC0, 8'($urandom_range(0, 7)));
      if (!p_valid[0] && !p_valid[1])
        new_req(1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFC0, 8'($urandom_range(0, 7)));
      run_burst(-1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1);
    end
    while (p_valid[0] || p_valid[1]) run_burst(-1, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
